// File: rtl/sram_arbiter_if.sv
// Requester-side bus of sram_arbiter: the PPU fetch port and the CPU/mapper PRG port.
// The core drives the master modport; the arbiter implements the slave modport.
interface sram_arbiter_if;
   logic        ppu_req;
   logic        ppu_we;
   logic [20:0] ppu_addr;
   logic [7:0]  ppu_wdata;
   logic        ppu_ack;
   logic [7:0]  ppu_rdata;
   logic        cpu_req;
   logic        cpu_we;
   logic [20:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;

   // req is held high until the one-cycle ack; rdata is valid with ack and held until the next read.
   modport master (
      output ppu_req, ppu_we, ppu_addr, ppu_wdata,
      input  ppu_ack, ppu_rdata,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata
   );

   modport slave (
      input  ppu_req, ppu_we, ppu_addr, ppu_wdata,
      output ppu_ack, ppu_rdata,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port byte arbiter and timing controller for a 1Mx16 asynchronous SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for alternating grants; otherwise the PPU has fixed priority.
module sram_arbiter #(
   parameter int ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   sram_arbiter_if.slave bus,
   output logic [19:0] sram_addr,
   inout  wire  [15:0] sram_data,
   output logic        sram_ce,
   output logic        sram_oe,
   output logic        sram_we,
   output logic        sram_ub,
   output logic        sram_lb,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [2:0] CNT_LOAD = 3'(ACCESS_CYCLES - 1);

   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n;
   logic        owner_cpu, owner_n;
   logic        acc_we, acc_we_n;
   logic        acc_lane, acc_lane_n;
   logic [7:0]  acc_wdata, acc_wdata_n;
   logic        drive, drive_n;
   logic [19:0] addr_n;
   logic        ce_n, oe_n, wen_n, ub_n, lb_n;
   logic        ppu_ack_q, ppu_ack_n, cpu_ack_q, cpu_ack_n;
   logic [7:0]  ppu_rdata_q, ppu_rdata_n, cpu_rdata_q, cpu_rdata_n;
   logic        pick_cpu;
   logic        grant_we;
   logic [20:0] grant_addr;
   logic [7:0]  grant_wdata;
   logic [7:0]  rd_byte;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic rr_cpu, rr_n;  // 1 = CPU is favoured on the next simultaneous request
   assign pick_cpu = bus.cpu_req && (!bus.ppu_req || rr_cpu);
`else
   assign pick_cpu = bus.cpu_req && !bus.ppu_req;
`endif

   assign grant_we    = pick_cpu ? bus.cpu_we    : bus.ppu_we;
   assign grant_addr  = pick_cpu ? bus.cpu_addr  : bus.ppu_addr;
   assign grant_wdata = pick_cpu ? bus.cpu_wdata : bus.ppu_wdata;
   assign rd_byte     = acc_lane ? sram_data[15:8] : sram_data[7:0];

   assign sram_data     = drive ? {acc_wdata, acc_wdata} : 16'hzzzz;
   assign bus.ppu_ack   = ppu_ack_q;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.ppu_rdata = ppu_rdata_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign dbg_state     = state;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      owner_n     = owner_cpu;
      acc_we_n    = acc_we;
      acc_lane_n  = acc_lane;
      acc_wdata_n = acc_wdata;
      addr_n      = sram_addr;
      ce_n        = 1'b1;
      oe_n        = 1'b1;
      wen_n       = 1'b1;
      ub_n        = 1'b1;
      lb_n        = 1'b1;
      drive_n     = 1'b0;
      ppu_ack_n   = 1'b0;
      cpu_ack_n   = 1'b0;
      ppu_rdata_n = ppu_rdata_q;
      cpu_rdata_n = cpu_rdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_n        = rr_cpu;
`endif
      case (state)
         IDLE: begin
            if (bus.ppu_req || bus.cpu_req) begin
               state_n     = ACCESS;
               cnt_n       = CNT_LOAD;
               owner_n     = pick_cpu;
               acc_we_n    = grant_we;
               acc_lane_n  = grant_addr[0];
               acc_wdata_n = grant_wdata;
               addr_n      = grant_addr[20:1];
               ce_n        = 1'b0;
               lb_n        = grant_addr[0];
               ub_n        = !grant_addr[0];
               oe_n        = grant_we;
               wen_n       = !grant_we;
               drive_n     = grant_we;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
               rr_n        = !pick_cpu;
`endif
            end
         end
         ACCESS: begin
            if (cnt == 3'd0) begin
               // Leaving ACCESS releases the bus on the same edge that raises sram_we.
               state_n = DONE;
               if (owner_cpu) begin
                  cpu_ack_n = 1'b1;
                  if (!acc_we) cpu_rdata_n = rd_byte;
               end else begin
                  ppu_ack_n = 1'b1;
                  if (!acc_we) ppu_rdata_n = rd_byte;
               end
            end else begin
               cnt_n   = cnt - 3'd1;
               ce_n    = 1'b0;
               lb_n    = acc_lane;
               ub_n    = !acc_lane;
               oe_n    = acc_we;
               wen_n   = !acc_we;
               drive_n = acc_we;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 3'd0;
         owner_cpu   <= 1'b0;
         acc_we      <= 1'b0;
         acc_lane    <= 1'b0;
         acc_wdata   <= 8'h00;
         drive       <= 1'b0;
         sram_addr   <= 20'h00000;
         sram_ce     <= 1'b1;
         sram_oe     <= 1'b1;
         sram_we     <= 1'b1;
         sram_ub     <= 1'b1;
         sram_lb     <= 1'b1;
         ppu_ack_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         ppu_rdata_q <= 8'h00;
         cpu_rdata_q <= 8'h00;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         rr_cpu      <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         owner_cpu   <= owner_n;
         acc_we      <= acc_we_n;
         acc_lane    <= acc_lane_n;
         acc_wdata   <= acc_wdata_n;
         drive       <= drive_n;
         sram_addr   <= addr_n;
         sram_ce     <= ce_n;
         sram_oe     <= oe_n;
         sram_we     <= wen_n;
         sram_ub     <= ub_n;
         sram_lb     <= lb_n;
         ppu_ack_q   <= ppu_ack_n;
         cpu_ack_q   <= cpu_ack_n;
         ppu_rdata_q <= ppu_rdata_n;
         cpu_rdata_q <= cpu_rdata_n;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         rr_cpu      <= rr_n;
`endif
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM; the SRAM model drives a
// marker pattern whenever sram_we is high and no read is enabled, exposing any stray DUT drive.
module tb_sram_arbiter;

   localparam logic [15:0] RELEASED = 16'hC33C;

   logic        clk;
   logic        rst;
   logic [19:0] sram_addr;
   wire  [15:0] sram_data;
   logic        sram_ce, sram_oe, sram_we, sram_ub, sram_lb;
   logic [1:0]  dbg_state;

   sram_arbiter_if bus ();

   sram_arbiter #(.ACCESS_CYCLES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .sram_addr (sram_addr),
      .sram_data (sram_data),
      .sram_ce   (sram_ce),
      .sram_oe   (sram_oe),
      .sram_we   (sram_we),
      .sram_ub   (sram_ub),
      .sram_lb   (sram_lb),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- SRAM model ----------------
   logic [15:0] mem [0:1023];
   assign sram_data = !sram_we ? 16'hzzzz :
                      (!sram_ce && !sram_oe) ? mem[sram_addr[9:0]] : RELEASED;

   always @(negedge clk) begin
      if (!sram_ce && !sram_we) begin
         if (!sram_lb) mem[sram_addr[9:0]][7:0]  = sram_data[7:0];
         if (!sram_ub) mem[sram_addr[9:0]][15:8] = sram_data[15:8];
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- bus monitor ----------------
   int          act_cycles, oe_low, we_low, gap, last_gap;
   logic [19:0] last_addr;
   logic        last_ub, last_lb;
   logic [15:0] last_wdata;

   always @(negedge clk) begin
      check("we_oe_exclusive", 32'(sram_we | sram_oe), 32'd1);
      if (sram_we && sram_oe) check("bus_released", 32'(sram_data), 32'(RELEASED));
      if (!sram_ce && !sram_oe) check("read_no_contention", 32'(sram_data), 32'(mem[sram_addr[9:0]]));
      if (!sram_ce) begin
         if (gap != 0) last_gap = gap;
         gap = 0;
         act_cycles++;
         last_addr = sram_addr;
         last_ub   = sram_ub;
         last_lb   = sram_lb;
         if (!sram_oe) oe_low++;
         if (!sram_we) begin
            we_low++;
            last_wdata = sram_data;
         end
      end else begin
         gap++;
      end
   end

   task automatic clear_mon();
      act_cycles = 0;
      oe_low     = 0;
      we_low     = 0;
      last_addr  = '0;
      last_ub    = 1'b1;
      last_lb    = 1'b1;
      last_wdata = '0;
   endtask

   // ---------------- driver ----------------
   // Call at a negedge; returns at the negedge where ack is seen (or after a 20-cycle budget).
   task automatic access(input bit is_cpu, input bit we, input logic [20:0] addr,
                         input logic [7:0] wdata, output logic [7:0] rdata, output int lat);
      if (is_cpu) begin
         bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
      end else begin
         bus.ppu_req = 1'b1; bus.ppu_we = we; bus.ppu_addr = addr; bus.ppu_wdata = wdata;
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(is_cpu ? bus.cpu_ack : bus.ppu_ack) && lat < 20);
      check("ack_timeout", 32'(lat < 20), 32'd1);
      check("other_ack_quiet", 32'(is_cpu ? bus.ppu_ack : bus.cpu_ack), 32'd0);
      rdata = is_cpu ? bus.cpu_rdata : bus.ppu_rdata;
      if (is_cpu) bus.cpu_req = 1'b0;
      else        bus.ppu_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   logic [0:0] exp_q[$];
   logic [7:0] rd;
   int         lat;
   int         acks, cyc, first_cpu_ack;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[10'h010] = 16'hBEEF;
      mem[10'h020] = 16'h1234;
      bus.ppu_req = 1'b0; bus.ppu_we = 1'b0; bus.ppu_addr = '0; bus.ppu_wdata = '0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      gap = 0; last_gap = 0;
      clear_mon();
      rst = 1'b0;
      #1 rst = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ce", 32'(sram_ce), 32'd1);
      check("rst_oe", 32'(sram_oe), 32'd1);
      check("rst_we", 32'(sram_we), 32'd1);
      check("rst_ub", 32'(sram_ub), 32'd1);
      check("rst_lb", 32'(sram_lb), 32'd1);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_data_z", 32'(sram_data), 32'(RELEASED));
      check("rst_acks", 32'({bus.ppu_ack, bus.cpu_ack}), 32'd0);
      check("rst_ppu_rdata", 32'(bus.ppu_rdata), 32'h00);
      check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h00);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single CPU read of the upper lane
      clear_mon();
      access(1'b1, 1'b0, 21'h00021, 8'h00, rd, lat);
      check("rd_latency", 32'(lat), 32'd3);
      check("rd_data", 32'(rd), 32'hBE);
      check("rd_active_cycles", 32'(act_cycles), 32'd2);
      check("rd_oe_cycles", 32'(oe_low), 32'd2);
      check("rd_we_cycles", 32'(we_low), 32'd0);
      check("rd_addr", 32'(last_addr), 32'h00010);
      check("rd_ub", 32'(last_ub), 32'd0);
      check("rd_lb", 32'(last_lb), 32'd1);
      check("rd_ppu_rdata_untouched", 32'(bus.ppu_rdata), 32'h00);
      @(negedge clk);
      check("ack_one_cycle", 32'(bus.cpu_ack), 32'd0);
      @(negedge clk);

      // Single PPU write of the lower lane, then read it back
      clear_mon();
      access(1'b0, 1'b1, 21'h00040, 8'h5A, rd, lat);
      check("wr_latency", 32'(lat), 32'd3);
      check("wr_active_cycles", 32'(act_cycles), 32'd2);
      check("wr_we_cycles", 32'(we_low), 32'd2);
      check("wr_oe_cycles", 32'(oe_low), 32'd0);
      check("wr_addr", 32'(last_addr), 32'h00020);
      check("wr_lb", 32'(last_lb), 32'd0);
      check("wr_ub", 32'(last_ub), 32'd1);
      check("wr_bus_data", 32'(last_wdata), 32'h5A5A);
      check("wr_mem_word", 32'(mem[10'h020]), 32'h125A);
      @(negedge clk);
      access(1'b0, 1'b0, 21'h00040, 8'h00, rd, lat);
      check("wr_readback", 32'(rd), 32'h5A);
      check("cpu_rdata_held", 32'(bus.cpu_rdata), 32'hBE);
      @(negedge clk);

      // Write -> read turnaround, read issued in the ack cycle of the write
      access(1'b1, 1'b1, 21'h00081, 8'hA7, rd, lat);
      access(1'b0, 1'b0, 21'h00081, 8'h00, rd, lat);
      check("turn_gap_cycles", 32'(last_gap), 32'd2);
      check("turn_read_data", 32'(rd), 32'hA7);
      check("turn_latency", 32'(lat), 32'd4);
      @(negedge clk);

      // Reset in the middle of an access
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 21'h00021;
      @(negedge clk);
      check("mid_in_access", 32'(sram_ce), 32'd0);
      rst = 1'b1;
      bus.cpu_req = 1'b0;
      #1;
      check("mid_rst_ce", 32'(sram_ce), 32'd1);
      check("mid_rst_oe", 32'(sram_oe), 32'd1);
      check("mid_rst_lanes", 32'({sram_ub, sram_lb}), 32'd3);
      check("mid_rst_ppu_rdata", 32'(bus.ppu_rdata), 32'h00);
      check("mid_rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         acks += int'(bus.cpu_ack) + int'(bus.ppu_ack);
      end
      check("mid_rst_no_ack", 32'(acks), 32'd0);

      // Contention from a fresh reset: both requests held high
      do_reset();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      bus.ppu_req = 1'b1; bus.ppu_we = 1'b0; bus.ppu_addr = 21'h00020;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 21'h00021;
      first_cpu_ack = 0;
      for (cyc = 1; cyc <= 24; cyc++) begin
         @(negedge clk);
         check("cont_single_ack", 32'(bus.ppu_ack & bus.cpu_ack), 32'd0);
         if (cyc <= 15) begin
            if (bus.ppu_ack || bus.cpu_ack) begin
               check("cont_ack_spacing", 32'(cyc % 4), 32'd3);
               if (exp_q.size() == 0) check("cont_extra_ack", 32'd1, 32'd0);
               else check("cont_ack_order", 32'(bus.cpu_ack), 32'(exp_q.pop_front()));
            end
            if (cyc == 15) bus.ppu_req = 1'b0;
         end else if (bus.cpu_ack && first_cpu_ack == 0) begin
            first_cpu_ack = cyc;
            bus.cpu_req = 1'b0;
         end else begin
            check("cont_ppu_quiet", 32'(bus.ppu_ack), 32'd0);
         end
      end
      check("cont_all_acks_seen", 32'(exp_q.size()), 32'd0);
      check("cont_cpu_after_drop", 32'(first_cpu_ack), 32'd19);
      bus.cpu_req = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and timing controller between the NES core and the board's 1M×16 asynchronous SRAM. It sits directly upstream of the SRAM pins: the PPU pattern/nametable fetch path and the CPU/mapper PRG path each issue byte requests, and this block serializes them onto sram_addr/sram_data with the active-low chip controls. It returns read bytes to each requester on a one-cycle acknowledge.

## Interface
- ACCESS_CYCLES, default 2: cycles the SRAM controls are held per access; legal range 1–7.
- Clk  input  1  system clock (master_clock domain)
- Reset  input  1  asynchronous, active-high reset
- ppu_req  input  1  PPU request; held high until ppu_ack
- ppu_we  input  1  1 = write, 0 = read
- ppu_addr  input  21  byte address; bit 0 selects the byte lane
- ppu_wdata  input  8  write byte
- ppu_ack  output  1  one-cycle completion pulse
- ppu_rdata  output  8  read byte; valid while ppu_ack is high, held until the next PPU read completes
- cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ack, cpu_rdata: same widths and rules as the PPU port
- sram_addr  output  20  word address = granted addr[20:1]
- sram_data  inout  16  driven only during write access, otherwise high-Z
- sram_ce, sram_oe, sram_we, sram_ub, sram_lb  output  1 each  active-low SRAM controls

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: all SRAM controls high and sram_data at Z. If any request is high at a rising edge, latch the winner's we/addr/wdata, load a counter with ACCESS_CYCLES-1, and go to ACCESS.
- Arbitration with ppu_req and cpu_req both high: the PPU wins (see Configuration).
- ACCESS: sram_ce=0. sram_lb=0 if addr[0]=0, else sram_ub=0; the other lane stays 1.
  - Read: sram_oe=0, sram_we=1.
  - Write: sram_we=0, sram_oe=1, sram_data={wdata,wdata}.
  - The counter decrements each cycle. At the edge where the counter is 0:
    - Read: capture the selected lane into the owner's rdata register.
    - Assert the owner's ack (registered) and go to DONE.
- DONE: all controls high, sram_data Z, ack high for exactly this cycle, then IDLE.
- A requester still asserting req in the cycle after ack is treated as a new request.
- Address and data are latched at grant, so requester inputs may change during ACCESS without effect.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All SRAM controls go to 1, sram_data to Z, sram_addr to 0.
  - Both acks go to 0, both rdata to 8'h00, and the round-robin pointer to PPU.
  - An access in flight is abandoned with no ack.

## Timing
- All outputs are registered. There is no combinational path from req to the SRAM pins.
- Request high at edge E0: controls are asserted after E0 for ACCESS_CYCLES cycles, and ack is high in the cycle after edge E0+ACCESS_CYCLES.
- Latency from req sample to ack = ACCESS_CYCLES+1 cycles. One access per ACCESS_CYCLES+2 cycles.
- With ACCESS_CYCLES=2, back-to-back requests complete every 4 cycles.
- sram_we is never low in the same cycle as sram_oe.
- DONE guarantees at least one cycle with both sram_we and sram_oe high between consecutive accesses, including write→read turnaround.
- sram_data is released to Z no later than the edge that deasserts sram_we.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN
  - Defined: on simultaneous requests, grant alternates, favouring the port not granted last. The pointer updates at each grant.
  - Undefined: fixed priority, PPU always wins; the CPU can be starved while ppu_req stays high.
  - Single-requester behaviour and timing are identical in both builds.

## Test plan
- Reset check: hold Reset=1 → all five SRAM controls 1, sram_data Z, both acks 0, both rdata 8'h00. Assert Reset mid-ACCESS → controls return to 1 immediately and no ack follows.
- Single read, ACCESS_CYCLES=2: preload word 20'h00010 = 16'hBEEF, cpu_req read addr 21'h00021 → sram_addr=20'h00010, sram_ub=0, sram_lb=1, sram_oe=0 for 2 cycles. cpu_ack fires 3 cycles after the sample with cpu_rdata=8'hBE.
- Single write: ppu write addr 21'h00040, wdata 8'h5A → sram_we=0, sram_lb=0, sram_ub=1 for 2 cycles, sram_data=16'h5A5A. Read back 21'h00040 → 8'h5A, and the upper byte of word 20'h00020 is unchanged.
- Contention, macro undefined: ppu_req and cpu_req held high continuously → only ppu_ack pulses, every 4 cycles. Drop ppu_req → the CPU is granted next.
- Contention, SRAM_ARB_ROUND_ROBIN_EN defined: both held high → acks alternate PPU, CPU, PPU, CPU, one every 4 cycles.
- Write→read turnaround: CPU write followed immediately by a PPU read → at least one cycle with sram_we=1 and sram_oe=1 between them, and sram_data is never driven while sram_oe=0.
